// File: rtl/xcore_if_btb_upd_ctrl.sv
// xcore_if_btb_upd_ctrl: BTB write-port arbiter with front-end deferral FIFO and invalidate sweep
module xcore_if_btb_upd_ctrl #(
    parameter int ENTRY_NUM  = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 16,
    parameter int TGT_W      = 16,
    parameter int WIDTH      = 32,
    localparam int ILEN      = $clog2(ENTRY_NUM),
    localparam int DW        = TAG_W + TGT_W + 4
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_flush,
    input  logic             i_bpu_btb_update,
    input  logic [WIDTH-1:0] i_bpu_instr_pc,
    input  logic [2:0]       i_bpu_btb_type,
    input  logic [WIDTH-1:0] i_bpu_btb_target,
    input  logic             i_bpu_btb_valid,
    input  logic             i_wb_cmt_req,
    input  logic [WIDTH-1:0] i_wb_instr_pc,
    input  logic [2:0]       i_wb_cmt_type,
    input  logic [WIDTH-1:0] i_wb_cmt_target,
    output logic             o_btb_we,
    output logic [ILEN-1:0]  o_btb_waddr,
    output logic [DW-1:0]    o_btb_wdata,
    output logic             o_busy,
    output logic [7:0]       o_drop_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_e;

    state_e              state_q, state_d;
    logic [ILEN-1:0]     sweep_q, sweep_d;
    logic                we_d;
    logic [ILEN-1:0]     waddr_d;
    logic [DW-1:0]       wdata_d;
    logic                busy_d;
    logic [7:0]          drop_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [ILEN-1:0]     fifo_idx_q [FIFO_DEPTH];
    logic [DW-1:0]       fifo_dat_q [FIFO_DEPTH];
    logic                push;
    logic [1:0]          drops;
    logic [8:0]          drop_sum;

    wire [ILEN-1:0] bpu_idx = i_bpu_instr_pc[ILEN+1:2];
    wire [ILEN-1:0] wb_idx  = i_wb_instr_pc[ILEN+1:2];
    wire [DW-1:0]   bpu_dat = {i_bpu_instr_pc[TAG_W-1:0], i_bpu_btb_valid,
                               i_bpu_btb_target[TGT_W-1:0], i_bpu_btb_type};
    wire [DW-1:0]   wb_dat  = {i_wb_instr_pc[TAG_W-1:0], 1'b1,
                               i_wb_cmt_target[TGT_W-1:0], i_wb_cmt_type};
    wire [1:0]      req_cnt = {1'b0, i_bpu_btb_update} + {1'b0, i_wb_cmt_req};
    wire            unused_hi = ^{i_bpu_instr_pc[WIDTH-1:TAG_W], i_wb_instr_pc[WIDTH-1:TAG_W],
                                  i_bpu_btb_target[WIDTH-1:TGT_W], i_wb_cmt_target[WIDTH-1:TGT_W]};

    // Next-state: flush/sweep take priority, otherwise WB > FIFO head > direct BPU write
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        we_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        live_d  = live_q;
        push    = 1'b0;
        drops   = '0;
        if (i_flush) begin
            state_d = FLUSH;
            sweep_d = '0;
            head_d  = '0;
            tail_d  = '0;
            cnt_d   = '0;
            live_d  = '0;
            drops   = req_cnt;
        end else if (state_q != IDLE) begin
            we_d    = 1'b1;
            waddr_d = sweep_q;
            sweep_d = sweep_q + 1'b1;
            state_d = (sweep_q == ILEN'(ENTRY_NUM - 1)) ? IDLE : state_q;
            drops   = req_cnt;
        end else if (i_wb_cmt_req) begin
            we_d    = 1'b1;
            waddr_d = wb_idx;
            wdata_d = wb_dat;
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (fifo_idx_q[i] == wb_idx) live_d[i] = 1'b0;
            if (i_bpu_btb_update && bpu_idx != wb_idx) begin
                drops = (cnt_q == CW'(FIFO_DEPTH)) ? 2'd1 : 2'd0;
                push  = (cnt_q != CW'(FIFO_DEPTH));
            end
        end else if (cnt_q != '0) begin
            we_d    = live_q[head_q];
            waddr_d = fifo_idx_q[head_q];
            wdata_d = fifo_dat_q[head_q];
            head_d  = head_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            push    = i_bpu_btb_update;
        end else if (i_bpu_btb_update) begin
            we_d    = 1'b1;
            waddr_d = bpu_idx;
            wdata_d = bpu_dat;
        end
        if (push) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + 1'b1;
            cnt_d          = cnt_d + 1'b1;
        end
    end

    // Busy covers every sweep write cycle and drops only once the FSM has settled in IDLE
    assign busy_d   = (state_q != IDLE) || (state_d != IDLE);
    assign drop_sum = {1'b0, o_drop_cnt} + {7'd0, drops};
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    // Control state and registered outputs
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q     <= INIT;
            sweep_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            live_q      <= '0;
            o_btb_we    <= 1'b0;
            o_btb_waddr <= '0;
            o_btb_wdata <= '0;
            o_busy      <= 1'b1;
            o_drop_cnt  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            live_q      <= live_d;
            o_btb_we    <= we_d;
            o_btb_waddr <= waddr_d;
            o_btb_wdata <= wdata_d;
            o_busy      <= busy_d;
            o_drop_cnt  <= drop_d;
        end
    end

    // FIFO payload storage; liveness and pointers guard its use, so no reset needed
    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            fifo_idx_q[tail_q] <= bpu_idx;
            fifo_dat_q[tail_q] <= bpu_dat;
        end
    end
endmodule

// File: tb/tb_xcore_if_btb_upd_ctrl.sv
// tb_xcore_if_btb_upd_ctrl: directed plus random checks of the BTB update controller against a queue model
module tb_xcore_if_btb_upd_ctrl;
    localparam int EN    = 128;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0, bu = 1'b0, bv = 1'b0, wr = 1'b0;
    logic [31:0] bpc = '0, btg = '0, wpc = '0, wtg = '0;
    logic [2:0]  bty = '0, wty = '0;
    logic        we, busy;
    logic [6:0]  waddr;
    logic [35:0] wdata;
    logic [7:0]  dcnt;

    xcore_if_btb_upd_ctrl dut (
        .i_sys_clk(clk), .i_sys_rst(rst_n), .i_flush(flush),
        .i_bpu_btb_update(bu), .i_bpu_instr_pc(bpc), .i_bpu_btb_type(bty),
        .i_bpu_btb_target(btg), .i_bpu_btb_valid(bv),
        .i_wb_cmt_req(wr), .i_wb_instr_pc(wpc), .i_wb_cmt_type(wty), .i_wb_cmt_target(wtg),
        .o_btb_we(we), .o_btb_waddr(waddr), .o_btb_wdata(wdata),
        .o_busy(busy), .o_drop_cnt(dcnt)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; logic [35:0] data; bit live;} ent_t;
    ent_t        q[$];
    int          sweep, drops, e_addr;
    bit          e_we, e_busy;
    logic [35:0] e_data;
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[8:2]);
    endfunction

    task automatic model_reset();
        q.delete();
        sweep  = 0;
        drops  = 0;
        e_we   = 0;
        e_addr = 0;
        e_data = '0;
        e_busy = 1;
    endtask

    task automatic push_bpu();
        ent_t e;
        e.idx  = idx_of(bpc);
        e.data = {bpc[15:0], bv, btg[15:0], bty};
        e.live = 1;
        q.push_back(e);
    endtask

    task automatic model_step();
        int   d;
        ent_t h;
        d = 0;
        e_we = 0;
        e_addr = 0;
        e_data = '0;
        if (flush) begin
            d = int'(bu) + int'(wr);
            q.delete();
            sweep = 0;
            e_busy = 1;
        end else if (sweep >= 0) begin
            d = int'(bu) + int'(wr);
            e_we = 1;
            e_addr = sweep;
            sweep++;
            if (sweep == EN) sweep = -1;
            e_busy = 1;
        end else begin
            e_busy = 0;
            if (wr) begin
                e_we = 1;
                e_addr = idx_of(wpc);
                e_data = {wpc[15:0], 1'b1, wtg[15:0], wty};
                foreach (q[i]) if (q[i].idx == e_addr) q[i].live = 0;
                if (bu && idx_of(bpc) != e_addr) begin
                    if (q.size() == DEPTH) d = 1;
                    else push_bpu();
                end
            end else if (q.size() > 0) begin
                h = q.pop_front();
                e_we = h.live;
                if (h.live) begin
                    e_addr = h.idx;
                    e_data = h.data;
                end
                if (bu) push_bpu();
            end else if (bu) begin
                e_we = 1;
                e_addr = idx_of(bpc);
                e_data = {bpc[15:0], bv, btg[15:0], bty};
            end
        end
        drops = (drops + d > 255) ? 255 : drops + d;
    endtask

    task automatic compare();
        chk("we", we, e_we);
        chk("busy", busy, e_busy);
        chk("drop_cnt", dcnt, drops);
        if (e_we) begin
            chk("waddr", waddr, e_addr);
            chk("wdata", wdata, e_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic check_reset_vals();
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 1);
        chk("rst_drop", dcnt, 0);
    endtask

    task automatic rand_bpu();
        logic [2:0] tys [3];
        tys = '{3'b100, 3'b010, 3'b001};
        bu  = ($urandom_range(9) < 6);
        bpc = {$urandom_range(32'hFFFF) , 16'h0} | 32'($urandom_range(15) << 2);
        btg = $urandom;
        bv  = 1'($urandom_range(1));
        bty = tys[$urandom_range(2)];
        wr  = ($urandom_range(9) < 3);
        wpc = {$urandom_range(32'hFFFF), 16'h0} | 32'($urandom_range(15) << 2);
        wtg = $urandom;
        wty = tys[$urandom_range(2)];
        flush = ($urandom_range(299) == 0);
    endtask

    task automatic idle_inputs();
        bu = 0; wr = 0; flush = 0;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 0;
        #2 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < EN; i++) begin
            step();
            chk("sweep_addr", waddr, i);
        end
        step();
        chk("busy_after_sweep", busy, 0);
        step();
        // direct BPU write
        bu = 1; bpc = 32'h0000_1040; btg = 32'h0000_2000; bty = 3'b100; bv = 1;
        step();
        idle_inputs();
        chk("tp_direct_addr", waddr, 7'h10);
        chk("tp_direct_data", wdata, {16'h1040, 1'b1, 16'h2000, 3'b100});
        // WB and BPU in the same cycle
        wr = 1; wpc = 32'h8; wtg = 32'h0000_0abc; wty = 3'b001;
        bu = 1; bpc = 32'hC; btg = 32'h0000_0123; bty = 3'b010; bv = 1;
        step();
        idle_inputs();
        chk("tp_wb_first", waddr, 7'd2);
        step();
        chk("tp_fifo_second", waddr, 7'd3);
        // FIFO fill with overflow drops
        for (int i = 0; i < 6; i++) begin
            wr = 1; wpc = 32'h200; wty = 3'b100;
            bu = 1; bpc = 32'h104 + 32'(i * 4); btg = 32'(i);
            step();
        end
        idle_inputs();
        chk("tp_drop2", dcnt, 2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tp_order", waddr, 7'h41 + 7'(i));
        end
        // kill queued entry
        wr = 1; wpc = 32'h400; bu = 1; bpc = 32'h100;
        step();
        bu = 0; wpc = 32'h100;
        step();
        wr = 0;
        chk("tp_kill_wb", waddr, 7'h40);
        step();
        chk("tp_killed_we", we, 0);
        // flush with pending FIFO entries and a same-cycle BPU request
        wr = 1; wpc = 32'h400; bu = 1; bpc = 32'h20;
        step();
        bpc = 32'h24;
        step();
        wr = 0; flush = 1; bpc = 32'h28;
        step();
        idle_inputs();
        chk("tp_flush_busy", busy, 1);
        chk("tp_flush_drop", dcnt, 3);
        for (int i = 0; i < EN + 3; i++) step();
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            rand_bpu();
            step();
        end
        idle_inputs();
        for (int i = 0; i < EN + 4; i++) step();
        // drop counter saturation
        flush = 1;
        step();
        flush = 0; bu = 1; wr = 1;
        for (int i = 0; i < EN + 2; i++) step();
        idle_inputs();
        chk("sat_drop", dcnt, 255);
        // asynchronous reset mid-sweep with pending state
        flush = 1;
        step();
        flush = 0;
        for (int i = 0; i < 20; i++) step();
        #2 rst_n = 0;
        #1 check_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < EN + 3; i++) begin
            rand_bpu();
            flush = 0;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xcore_if_btb_upd_ctrl.md
Name: xcore_if_btb_upd_ctrl

Overview:
Write-port controller and sequencer for the 128-entry BTB RAM (tag16/valid1/target16/type3, 36-bit entries). Arbitrates the single BTB write port between front-end (BPU) speculative updates and back-end (WB) commit updates. Buffers deferred front-end updates in a small FIFO. Runs an invalidate sweep after reset and on flush, because the RAM contents are not reset.

Parameters:
ENTRY_NUM, 128, number of BTB entries; ILEN = $clog2(ENTRY_NUM)
FIFO_DEPTH, 4, front-end deferral FIFO depth (power of 2, >=2)
TAG_W, 16, tag width taken from pc[TAG_W-1:0]
TGT_W, 16, stored target width taken from target[TGT_W-1:0]

Ports:
i_sys_clk  in  1  system clock
i_sys_rst  in  1  asynchronous active-low reset
i_flush  in  1  request full BTB invalidate (single-cycle pulse)
i_bpu_btb_update  in  1  front-end update request
i_bpu_instr_pc  in  `WIDTH  front-end update PC
i_bpu_btb_type  in  3  branch 100, jal 010, jalr 001
i_bpu_btb_target  in  `WIDTH  front-end target
i_bpu_btb_valid  in  1  valid bit to store
i_wb_cmt_req  in  1  back-end commit update request
i_wb_instr_pc  in  `WIDTH  commit PC
i_wb_cmt_type  in  3  commit type
i_wb_cmt_target  in  `WIDTH  commit target
o_btb_we  out  1  BTB write enable
o_btb_waddr  out  ILEN  BTB write index
o_btb_wdata  out  36  {tag, valid, target, type}
o_busy  out  1  sweep in progress; BTB lookups must be treated as miss
o_drop_cnt  out  8  saturating count of discarded updates

Behaviour:
- Clock i_sys_clk; reset i_sys_rst is asynchronous and active-low. All outputs are registered.
- Reset values: o_btb_we=0, o_btb_waddr=0, o_btb_wdata=0, o_busy=1, o_drop_cnt=0. FIFO is empty. FSM is in INIT with sweep_idx=0.
- Index is pc[ILEN+1:2]. Tag is pc[TAG_W-1:0]. Target field is target[TGT_W-1:0].
- FSM states: INIT, IDLE, FLUSH.
- INIT/FLUSH sweep behaviour:
  - One write per cycle: we=1, waddr=sweep_idx, wdata=0.
  - sweep_idx increments by 1. The write at ENTRY_NUM-1 is the last; the next cycle goes to IDLE and o_busy=0.
  - A full sweep takes exactly ENTRY_NUM write cycles.
- Sweep timing and interaction:
  - The first sweep write appears in the cycle after reset deassertion.
  - i_flush in IDLE: next cycle enters FLUSH with sweep_idx=0, o_busy=1, FIFO cleared (pending entries discarded, not counted).
  - i_flush during INIT/FLUSH restarts the sweep with sweep_idx=0.
  - Update requests (BPU or WB) arriving during INIT/FLUSH, or in the same cycle as an accepted i_flush, are discarded. Each one increments o_drop_cnt.
- IDLE arbitration, evaluated each cycle; the resulting write appears on the outputs the next cycle (latency 1):
  1. i_wb_cmt_req: write {wb tag, 1, wb target, wb type}.
  2. Else FIFO non-empty: pop head. If the head is live, write it. If it was killed, no write (we=0) this cycle.
  3. Else i_bpu_btb_update: write the front-end entry directly with its i_bpu_btb_valid.
- Front-end update not written directly (WB active or FIFO non-empty):
  - Push to FIFO tail if not full.
  - If full, discard it and increment o_drop_cnt.
  - Push and pop in the same cycle is allowed when full: the pop frees a slot, so no drop.
- Commit kill:
  - A WB write invalidates (kills) every FIFO entry whose index equals the WB index.
  - A same-cycle BPU request with the same index as the WB request is discarded silently: no FIFO push, no drop count.
- FIFO order is strict: front-end updates are written in arrival order.
- o_drop_cnt saturates at 255 and is cleared only by reset.
- Reset asserted mid-sweep or with a non-empty FIFO returns everything to reset values and restarts INIT.
- o_btb_we is 0 in any IDLE cycle with no selected write.

Test Plan:
- Release reset, no requests -> we=1 for 128 consecutive cycles with waddr 0..127 and wdata=0; o_busy falls to 0 in the cycle after waddr=127; then we=0.
- IDLE, BPU update pc=0x0000_1040, target=0x0000_2000, type=100, valid=1 -> next cycle we=1, waddr=0x10, wdata={16'h1040,1,16'h2000,3'b100}.
- Same cycle WB pc=0x0000_0008 and BPU pc=0x0000_000C -> cycle+1 writes idx 2 (WB, valid=1); cycle+2 writes idx 3 from the FIFO.
- WB held for 6 cycles while BPU requests each cycle with distinct indices -> the first 4 are queued, 2 are dropped (o_drop_cnt=2); after WB stops, the 4 queued entries are written in order.
- BPU pc=0x0000_0100 queued behind WB, then WB pc=0x0000_0100 -> WB write to idx 0x40; the popped queued entry yields a cycle with we=0 (killed).
- i_flush with 2 FIFO entries pending plus a same-cycle BPU request -> o_busy=1, 128-write sweep, FIFO empty after, o_drop_cnt incremented by 1.
